// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and defaults for the UART transmit path
//
// Contents:
//   tx_state_t      - 3-bit serializer state encoding (IDLE, START, DATA, PARITY, STOP)
//   DEF_BITWIDTH    - default data byte / baud divisor width
//   DEF_OVERSAMPLE  - default baud ticks per serial bit
package uart_pkg;

    localparam int DEF_BITWIDTH   = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - programmable baud tick generator for the transmit serializer
//
// Ports:
//   pclk      in   core clock, rising edge
//   presetn   in   asynchronous active-low reset
//   en        in   counter runs while high
//   clr       in   synchronous clear, dominates en
//   baud_val  in   divisor; one tick every baud_val+1 enabled cycles
//   tick      out  high in the cycle the counter equals baud_val
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                en,
    input  logic                clr,
    input  logic [BITWIDTH-1:0] baud_val,
    output logic                tick
);

    logic [BITWIDTH-1:0] cnt;

    // baud_val is compared live; a mid-frame change only disturbs that frame's timing.
    assign tick = en && (cnt == baud_val);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == baud_val) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit FIFO plus 8N1 / 8-bit-plus-parity serializer
//
// Ports:
//   pclk, presetn          core clock and asynchronous active-low reset
//   baud_val               baud divisor (tick every baud_val+1 cycles)
//   tx_data, tx_wr         byte to send and its one-cycle write strobe
//   parity_en, parity_odd  parity enable and sense, latched per frame at pop
//   txd                    registered serial output, idles high
//   tf_full, tf_empty      registered FIFO status
//   tx_busy                a frame is in progress
//   tx_done                one-cycle pulse after each stop bit
//   tx_ovf                 one-cycle pulse after a write hit a full FIFO
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int BITWIDTH   = DEF_BITWIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [BITWIDTH-1:0] baud_val,
    input  logic [BITWIDTH-1:0] tx_data,
    input  logic                tx_wr,
    input  logic                parity_en,
    input  logic                parity_odd,
    output logic                txd,
    output logic                tf_full,
    output logic                tf_empty,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                tx_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(BITWIDTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITWIDTH - 1);

    // ---------------- transmit FIFO ----------------
    logic [BITWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic                wr_acc;
    logic                pop;

    tx_state_t           state;

    // Acceptance uses the registered full flag, so a same-cycle pop cannot rescue a write.
    assign wr_acc = tx_wr && !tf_full;
    assign pop    = (state == IDLE) && !tf_empty;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !wr_acc) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tf_full  <= 1'b0;
            tf_empty <= 1'b1;
            tx_ovf   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            tf_full  <= (count_nxt == FULL_CNT);
            tf_empty <= (count_nxt == '0);
            tx_ovf   <= tx_wr && tf_full;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge pclk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // ---------------- baud and bit timing ----------------
    logic            tick;
    logic            bit_end;
    logic [OS_W-1:0] os_cnt;

    uart_baud_gen #(
        .BITWIDTH (BITWIDTH)
    ) u_baud_gen (
        .pclk     (pclk),
        .presetn  (presetn),
        .en       (state != IDLE),
        .clr      (state == IDLE),
        .baud_val (baud_val),
        .tick     (tick)
    );

    assign bit_end = tick && (os_cnt == OS_LAST);
    assign tx_busy = (state != IDLE);

    // ---------------- serializer ----------------
    logic [BITWIDTH-1:0] shift;
    logic [BIT_W-1:0]    bit_cnt;
    logic                par_en_q;
    logic                par_bit;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            os_cnt   <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (state == IDLE) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end

            // txd is loaded together with each state change so it never glitches.
            case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    bit_cnt <= '0;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        par_en_q <= parity_en;
                        // Parity is computed once at load since shift is consumed during DATA.
                        par_bit  <= (^mem[rd_ptr]) ^ parity_odd;
                        txd      <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd   <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            if (par_en_q) begin
                                txd   <= par_bit;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            txd     <= shift[1];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        txd     <= 1'b1;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
